// File: rtl/regfile_pkg.sv
// Shared types for the register-file dump path: address type, dump FSM states.
package regfile_pkg;

  localparam int REGFILE_ADDR_W = 5;

  typedef logic [REGFILE_ADDR_W-1:0] regaddr_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } dump_state_t;

endpackage : regfile_pkg

// File: rtl/regfile_dump_if.sv
// Valid/ready beat stream carrying one (address, data) pair per beat.
interface regfile_dump_if #(
  parameter int Dbits = 32
) ();

  logic                   out_valid;
  logic                   out_ready;
  regfile_pkg::regaddr_t  out_addr;
  logic [Dbits-1:0]       out_data;

  // Producer side: the dump engine.
  modport master (
    output out_valid,
    output out_addr,
    output out_data,
    input  out_ready
  );

  // Consumer side: the trace/debug sink.
  modport slave (
    input  out_valid,
    input  out_addr,
    input  out_data,
    output out_ready
  );

endinterface : regfile_dump_if

// File: rtl/regfile_dump.sv
// Sweeps register-file locations 0..Nloc-1 through a spare combinational read
// port and streams each (address, data) pair over a valid/ready handshake.
// A beat is captured only when the output slot is free, so a stalled beat
// keeps the contents it had at its capture edge even if the file is written.
module regfile_dump
  import regfile_pkg::*;
#(
  parameter int Nloc  = 32,
  parameter int Dbits = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  output regaddr_t          rd_addr,
  input  logic [Dbits-1:0]  rd_data,
  regfile_dump_if.master    dump,
  output logic              busy,
  output logic              done
);

  localparam regaddr_t LAST_ADDR = regaddr_t'(Nloc - 1);

  dump_state_t       state_q, state_d;
  regaddr_t          addr_q, addr_d;
  regaddr_t          oaddr_q, oaddr_d;
  logic [Dbits-1:0]  odata_q, odata_d;
  logic              ovalid_q, ovalid_d;
  logic              done_q, done_d;
  logic              slot_free;
  logic              accept;

  assign slot_free = !ovalid_q || dump.out_ready;
  assign accept    = ovalid_q && dump.out_ready;

  // Next-state, address counter and output-slot update.
  always_comb begin
    // NOTE: every output of this block is given a default first, so no path leaves one unassigned and no latch is inferred.
    state_d  = state_q;
    addr_d   = addr_q;
    oaddr_d  = oaddr_q;
    odata_d  = odata_q;
    ovalid_d = ovalid_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // abort has priority over a simultaneous start
        if (start && !abort) begin
          addr_d  = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        if (abort) begin
          ovalid_d = 1'b0;
          addr_d   = '0;
          state_d  = IDLE;
        end else if (slot_free) begin
          odata_d  = rd_data;
          oaddr_d  = addr_q;
          ovalid_d = 1'b1;
          if (addr_q == LAST_ADDR) begin
            state_d = DRAIN;
          end else begin
            addr_d = addr_q + 5'd1;
          end
        end
      end

      DRAIN: begin
        if (abort) begin
          ovalid_d = 1'b0;
          addr_d   = '0;
          state_d  = IDLE;
        end else if (accept) begin
          ovalid_d = 1'b0;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end

      default: begin
        state_d  = IDLE;
        ovalid_d = 1'b0;
        addr_d   = '0;
      end
    endcase
  end

  // State register plus counter and output slot, all cleared by reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      oaddr_q  <= '0;
      // NOTE: the data register is cleared as well so out_data reads 0 after reset rather than a leftover word.
      odata_q  <= '0;
      ovalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the pre-edge values computed above.
      state_q  <= state_d;
      addr_q   <= addr_d;
      oaddr_q  <= oaddr_d;
      odata_q  <= odata_d;
      ovalid_q <= ovalid_d;
      done_q   <= done_d;
    end
  end

  assign rd_addr        = addr_q;
  assign dump.out_valid = ovalid_q;
  assign dump.out_addr  = oaddr_q;
  assign dump.out_data  = odata_q;
  assign busy           = (state_q == RUN) || (state_q == DRAIN);
  assign done           = done_q;

endmodule : regfile_dump

// File: doc/regfile_dump.md
Name: regfile_dump

Overview:
- Sequential reader that sweeps every location of the 32x32 register file through one of its read ports.
- Streams each (address, data) pair out over a valid/ready handshake.
- Used by the debug/trace path to dump architectural state without stalling the write side.
- Sits beside the register file; its read-address output drives a spare read-address input, and the matching read-data output returns to it.

Parameters:
- Nloc, 32, number of register-file locations swept (addresses 0..Nloc-1; at most 32).
- Dbits, 32, register data width.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
- abort  input  1  synchronous cancel of a dump in progress.
- rd_addr  output  5  read address driven to the register-file read port.
- rd_data  input  Dbits  combinational read data returned for rd_addr.
- out_valid  output  1  out_addr/out_data hold a valid beat.
- out_ready  input  1  consumer accepts the beat when out_valid and out_ready are both 1 at a rising edge.
- out_addr  output  5  address of the current beat.
- out_data  output  Dbits  data of the current beat.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE, addr counter=0, rd_addr=0, out_valid=0, out_addr=0, out_data=0, busy=0, done=0.
- States: IDLE, RUN, DRAIN. busy is decoded from the registered state.
- rd_addr equals the registered addr counter. rd_data is sampled in the same cycle (the read port is combinational).
- IDLE:
  - start=1 and abort=0 -> addr<=0, go to RUN.
  - Otherwise stay in IDLE.
  - done is 0 except for the pulse cycle described under DRAIN.
- RUN: "slot free" means out_valid=0 or out_ready=1.
  - Slot free:
    - Capture out_data<=rd_data, out_addr<=addr, out_valid<=1.
    - If addr==Nloc-1, go to DRAIN; else addr<=addr+1.
  - Slot not free: hold addr, out_*, and out_valid unchanged.
- Throughput: 1 beat/cycle with out_ready held at 1. First out_valid appears 2 edges after start is sampled.
- Full Nloc=32 dump with out_ready=1: beats on 32 consecutive cycles, done on the cycle after the last beat is accepted.
- Stability: while out_valid=1 and out_ready=0, out_addr and out_data must not change, even if the register file is written meanwhile.
- DRAIN:
  - out_valid=1 and out_ready=1 -> out_valid<=0, done<=1 for exactly one cycle, go to IDLE.
  - Otherwise hold.
- abort=1 in RUN or DRAIN: next edge out_valid<=0, addr<=0, go to IDLE, no done pulse. A beat handshaking in that same cycle counts as accepted.
- start=1 while busy: ignored. start and abort both 1 in IDLE: abort wins, stay in IDLE.
- Address 0: the register-file port already returns 0. This block passes rd_data through unmodified.
- Coherency: each beat reflects register contents at its capture edge. A write to location k is visible in beat k only if it committed before beat k was captured. No snapshot of the whole file is guaranteed.
- Counter never wraps past Nloc-1. Nloc<32 leaves the upper addresses unswept.
- Reset asserted mid-dump: immediate return to the reset values, with no done pulse.

Decomposition:
- Shared package regfile_pkg:
  - typedef regaddr_t (logic [4:0]).
  - typedef dump_state_t enum {IDLE, RUN, DRAIN}.
  - constant REGFILE_ADDR_W=5.
- Single module: FSM, address counter and output register in one file. No sub-module is warranted.

Test Plan:
- Preload rf[k]=32'hA000_0000+k; start pulse; out_ready=1 -> 32 beats on consecutive cycles with (addr,data)=(0,0),(1,A0000001)...(31,A000001F); done=1 one cycle after beat 31; busy drops with done.
- Same preload; out_ready=0 for cycles 3-6 of the dump, then 1 -> beat (2,A0000002) held stable for 4 cycles; no beat lost or duplicated; 32 beats total.
- During a dump with out_ready=0 and beat 5 pending, write rf[5]=32'hDEAD_BEEF and rf[20]=32'h1234_5678 -> beat 5 still A0000005; beat 20 = 12345678.
- abort asserted while beat 10 is pending -> out_valid=0 next cycle; busy=0; done never pulses; a new start restarts at addr 0.
- start pulses while busy and start+abort together in IDLE -> no restart, state unchanged; reset_n pulled low mid-dump -> all outputs 0 immediately, no done.
- Nloc=8 build -> exactly 8 beats (addr 0..7), done after beat 7.
